// File: rtl/ram_test_pkg.sv
// Shared constants and types for the on-chip RAM test master.
package ram_test_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/ram_test_patgen.sv
// Test-pattern generator: restart loads the first word, advance steps to the next word.
// Output is registered; pattern is valid in the cycle after restart.
module ram_test_patgen #(
    parameter int              DW   = ram_test_pkg::DEF_DW,
    parameter logic [DW-1:0]   POLY = ram_test_pkg::LFSR_POLY
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          advance,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] seed,
    output logic [DW-1:0] pattern
);
    import ram_test_pkg::*;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;
    logic [DW-1:0] first;

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_INC:  nxt = cur + ONE;
            MODE_LFSR: nxt = (cur >> 1) ^ (cur[0] ? POLY : '0);
            MODE_ALT:  nxt = ~cur;
            default:   nxt = cur;
        endcase
    end

    // An all-zero LFSR would lock up, so seed 0 is promoted to 1.
    assign first = (mode == MODE_LFSR && seed == '0) ? ONE : seed;

    always_ff @(posedge clk) begin
        if (reset)
            cur <= '0;
        else if (restart)
            cur <= first;
        else if (advance)
            cur <= nxt;
    end

    assign pattern = cur;

endmodule

// File: rtl/ram_test_master.sv
// Avalon-MM master that writes a pattern over a RAM range, reads it back and checks it.
// Runs 2N+1 busy cycles (1-cycle read latency); never stalls, start ignored while busy.
module ram_test_master #(
    parameter int            AW        = ram_test_pkg::DEF_AW,
    parameter int            DW        = ram_test_pkg::DEF_DW,
    parameter logic [DW-1:0] LFSR_POLY = ram_test_pkg::LFSR_POLY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       word_count,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     seed,
    output logic [AW-1:0]     ram_address,
    output logic [DW/8-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DW-1:0]     ram_writedata,
    output logic              ram_clken,
    input  logic [DW-1:0]     ram_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW:0]       err_count,
    output logic [AW-1:0]     first_err_addr,
    output logic [DW-1:0]     first_err_data
);
    import ram_test_pkg::*;

    localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_W     = {{AW{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [AW:0]     idx_q;
    logic [AW:0]     n_q;
    logic [AW:0]     count_clamped;
    logic [AW-1:0]   base_q;
    logic [1:0]      mode_q;
    logic [DW-1:0]   seed_q;
    logic            last_word;
    logic            cmp_vld;
    logic [DW-1:0]   cmp_exp;
    logic [AW-1:0]   cmp_addr;
    logic            mismatch;
    logic            pg_restart;
    logic            pg_advance;
    logic [1:0]      pg_mode;
    logic [DW-1:0]   pg_seed;
    logic [DW-1:0]   pattern;

    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign last_word     = (idx_q + ONE_W) == n_q;
    assign mismatch      = cmp_vld && (ram_readdata != cmp_exp);

    // In IDLE the generator must see the live inputs, since they are latched on the same edge.
    assign pg_mode    = (state_q == ST_IDLE) ? mode : mode_q;
    assign pg_seed    = (state_q == ST_IDLE) ? seed : seed_q;
    assign pg_restart = (state_q == ST_IDLE && start) || (state_q == ST_WRITE && last_word);
    assign pg_advance = (state_q == ST_WRITE) || (state_q == ST_READ);

    ram_test_patgen #(
        .DW   (DW),
        .POLY (LFSR_POLY)
    ) u_patgen (
        .clk     (clk),
        .reset   (reset),
        .restart (pg_restart),
        .advance (pg_advance),
        .mode    (pg_mode),
        .seed    (pg_seed),
        .pattern (pattern)
    );

    always_comb begin
        state_d        = state_q;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        busy           = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && count_clamped != '0)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_writedata  = pattern;
                if (last_word)
                    state_d = ST_READ;
            end
            ST_READ: begin
                ram_chipselect = 1'b1;
                if (last_word)
                    state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_address    = base_q + idx_q[AW-1:0];
    assign ram_byteenable = '1;
    assign ram_clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            n_q            <= '0;
            base_q         <= '0;
            mode_q         <= MODE_CONST;
            seed_q         <= '0;
            cmp_vld        <= 1'b0;
            cmp_exp        <= '0;
            cmp_addr       <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            state_q  <= state_d;
            done     <= 1'b0;
            cmp_vld  <= (state_q == ST_READ);
            cmp_exp  <= pattern;
            cmp_addr <= ram_address;

            if (state_q == ST_IDLE && start) begin
                n_q            <= count_clamped;
                base_q         <= base_addr;
                mode_q         <= mode;
                seed_q         <= seed;
                idx_q          <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
                pass           <= 1'b0;
                if (count_clamped == '0) begin
                    done <= 1'b1;
                    pass <= 1'b1;
                end
            end else if (state_q == ST_WRITE || state_q == ST_READ) begin
                idx_q <= last_word ? '0 : idx_q + ONE_W;
            end

            if (mismatch) begin
                err_count <= err_count + ONE_W;
                if (err_count == '0) begin
                    first_err_addr <= cmp_addr;
                    first_err_data <= ram_readdata;
                end
            end

            // The final word is compared during DRAIN, so fold it into the verdict here.
            if (state_q == ST_DRAIN) begin
                done <= 1'b1;
                pass <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_ram_test_master.sv
// Randomized scoreboard bench for ram_test_master with an ideal 1-cycle-latency RAM model.
module tb_ram_test_master;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     word_count;
    logic [1:0]      mode;
    logic [DW-1:0]   seed;
    logic [AW-1:0]   ram_address;
    logic [DW/8-1:0] ram_byteenable;
    logic            ram_chipselect;
    logic            ram_write;
    logic [DW-1:0]   ram_writedata;
    logic            ram_clken;
    logic [DW-1:0]   ram_readdata;
    logic            busy;
    logic            done;
    logic            pass;
    logic [AW:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic [DW-1:0]   first_err_data;

    ram_test_master dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .mode           (mode),
        .seed           (seed),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        bit          pass;
        int          errs;
        int          fea;
        logic [31:0] fed;
    } res_t;
    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    res_t       rq[$];
    wr_t        wq[$];
    logic [9:0] rdq[$];

    logic [31:0] mem [DEPTH];
    bit          flip [DEPTH];
    int          n_done = 0;
    int          run_s  = 0;
    int          run_n  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ideal RAM with one-cycle read latency; flipped addresses corrupt bit 0 on readback.
    always @(posedge clk) begin
        if (ram_chipselect && ram_write)
            mem[ram_address] <= ram_writedata;
        if (ram_chipselect)
            ram_readdata <= mem[ram_address] ^ {31'b0, flip[ram_address]};
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a bus access or a done pulse.
    always @(negedge clk) begin
        if (ram_chipselect && ram_write) begin
            if (wq.size() == 0) check("unexpected_write", {22'b0, ram_address}, 64'hFFFF);
            else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", ram_address, w.a);
                check("wr_data", ram_writedata, w.d);
            end
        end else if (ram_chipselect) begin
            if (rdq.size() == 0) check("unexpected_read", {22'b0, ram_address}, 64'hFFFF);
            else check("rd_addr", ram_address, rdq.pop_front());
        end
        if (done) begin
            n_done++;
            if (rq.size() == 0) check("unexpected_done", done, 1'b0);
            else begin
                res_t r;
                r = rq.pop_front();
                check("done_cycle", cyc, r.cyc);
                check("pass", pass, r.pass);
                check("err_count", err_count, r.errs);
                if (r.errs > 0) begin
                    check("first_err_addr", first_err_addr, r.fea);
                    check("first_err_data", first_err_data, r.fed);
                end
            end
        end
        if (!reset)
            check("busy", busy, (run_n > 0) && cyc >= run_s && cyc <= run_s + 2 * run_n);
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_test(input int b, input int cnt, input logic [1:0] md,
                            input logic [31:0] sd, input bit poke);
        int          n;
        int          d0;
        int          a;
        bit          got;
        logic [31:0] lf;
        logic [31:0] p;
        res_t        r;
        n     = (cnt > DEPTH) ? DEPTH : cnt;
        lf    = (sd == 0) ? 32'd1 : sd;
        r.errs = 0;
        r.fea  = 0;
        r.fed  = 0;
        for (int i = 0; i < n; i++) begin
            case (md)
                2'd0:    p = sd;
                2'd1:    p = sd + 32'(i);
                2'd2:    p = lf;
                default: p = (i % 2 == 1) ? ~sd : sd;
            endcase
            lf = lfsr_next(lf);
            a  = (b + i) % DEPTH;
            wq.push_back('{a: 10'(a), d: p});
            rdq.push_back(10'(a));
            if (flip[a]) begin
                if (r.errs == 0) begin
                    r.fea = a;
                    r.fed = p ^ 32'd1;
                end
                r.errs++;
            end
        end
        r.pass     = (r.errs == 0);
        d0         = n_done;
        base_addr  = 10'(b);
        word_count = 11'(cnt);
        mode       = md;
        seed       = sd;
        start      = 1'b1;
        next_cycle();
        start  = 1'b0;
        r.cyc  = (n == 0) ? cyc : cyc + 2 * n + 1;
        rq.push_back(r);
        run_s  = cyc;
        run_n  = n;
        if (poke) begin
            next_cycle();
            base_addr  = 10'd500;
            word_count = 11'd1;
            mode       = 2'd1;
            seed       = 32'h1234;
            start      = 1'b1;
            next_cycle();
            start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 2 * n + 20 && !got; k++) begin
            next_cycle();
            if (n_done > d0) got = 1'b1;
        end
        if (!got) check("done_timeout", 0, 1);
        check("writes_left", wq.size(), 0);
        check("reads_left", rdq.size(), 0);
        wq.delete();
        rdq.delete();
        rq.delete();
        repeat (2) next_cycle();
    endtask

    task automatic clear_flips();
        for (int i = 0; i < DEPTH; i++) flip[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_flips();
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = 11'd4;
        mode       = '0;
        seed       = '0;
        repeat (3) next_cycle();
        start = 1'b1;  // start coinciding with reset must be ignored
        next_cycle();
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_cs", ram_chipselect, 1'b0);
        check("rst_write", ram_write, 1'b0);
        check("rst_clken", ram_clken, 1'b1);
        check("rst_be", ram_byteenable, 4'hF);
        check("rst_addr", ram_address, 0);
        check("rst_wdata", ram_writedata, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 0);
        check("rst_fea", first_err_addr, 0);
        check("rst_fed", first_err_data, 0);
        next_cycle();

        run_test(0, 4, 2'd1, 32'h100, 1'b0);
        run_test(1022, 4, 2'd1, $urandom, 1'b0);

        flip[3] = 1'b1;
        flip[5] = 1'b1;
        run_test(0, 8, 2'd0, 32'hA5A5A5A5, 1'b0);
        clear_flips();

        run_test(77, 0, 2'd1, 32'h55, 1'b0);
        run_test($urandom_range(0, 1023), 2000, 2'd1, $urandom, 1'b0);
        run_test(10, 16, 2'd2, 32'h0, 1'b0);
        run_test(200, 6, 2'd3, 32'hFFFF0000, 1'b1);

        // Abort an 8-word run with reset during cycle 3.
        base_addr  = 10'd300;
        word_count = 11'd8;
        mode       = 2'd1;
        seed       = 32'hABC;
        for (int i = 0; i < 8; i++) wq.push_back('{a: 10'(300 + i), d: 32'hABC + 32'(i)});
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        run_s = cyc;
        run_n = 8;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        run_n = 0;
        wq.delete();
        @(negedge clk);
        check("abort_cs", ram_chipselect, 1'b0);
        check("abort_write", ram_write, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_err", err_count, 0);
        check("abort_pass", pass, 1'b0);
        repeat (30) next_cycle();
        check("abort_no_done", n_done, 7);

        run_test(300, 8, 2'd1, 32'hABC, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int b;
            int c;
            b = $urandom_range(0, 1023);
            c = $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 1) flip[(b + $urandom_range(0, c - 1)) % DEPTH] = 1'b1;
            if ($urandom_range(0, 2) == 0) flip[(b + $urandom_range(0, c - 1)) % DEPTH] = 1'b1;
            run_test(b, c, 2'($urandom_range(0, 3)), $urandom, 1'b0);
            clear_flips();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
